// File: rtl/sddr_init_refresh.sv
// DDR3 power-up sequencer (reset, CKE, MR2/MR3/MR1/MR0, ZQCL) followed by a
// periodic auto-refresh scheduler that banks up to eight owed refreshes.
module sddr_init_refresh #(
   parameter int BANK_BITS   = 3,
   parameter int ROW_BITS    = 13,
   parameter int DATA_BITS   = 16,
   parameter int T_RESET_CYC = 40000,
   parameter int T_CKE_CYC   = 100000,
   parameter int T_MRD       = 4,
   parameter int T_MOD       = 12,
   parameter int T_ZQINIT    = 512,
   parameter int T_REFI      = 6240,
   parameter int T_RFC       = 128,
   parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR0_VAL = '0,
   parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR1_VAL = '0,
   parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR2_VAL = '0,
   parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR3_VAL = '0
) (
   input  logic                                        in_ddr_clock_i,
   input  logic                                        in_reset_p_i,
   input  logic                                        usr_busy_i,
   output logic                                        ddr_reset_n_o,
   output logic                                        ctl_cke_o,
   output logic                                        ctl_cs_n_o,
   output logic                                        ctl_ras_n_o,
   output logic                                        ctl_cas_n_o,
   output logic                                        ctl_we_n_o,
   output logic                                        ctl_odt_o,
   output logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0]     ctl_addr_o,
   output logic [BANK_BITS-1:0]                        ctl_ba_o,
   output logic                                        ready_o,
   output logic                                        ref_busy_o,
   output logic                                        ref_overflow_o
);

   localparam int ADDR_W = ROW_BITS + $clog2(DATA_BITS/8);
   localparam int M1     = (T_RESET_CYC > T_CKE_CYC) ? T_RESET_CYC : T_CKE_CYC;
   localparam int M2     = (M1 > T_ZQINIT) ? M1 : T_ZQINIT;
   localparam int M3     = (M2 > T_MOD) ? M2 : T_MOD;
   localparam int M4     = (M3 > T_RFC) ? M3 : T_RFC;
   localparam int MAXT   = (M4 > T_MRD) ? M4 : T_MRD;
   localparam int CNT_W  = $clog2(MAXT + 1);
   localparam int REFI_W = $clog2(T_REFI + 1);

   localparam logic [3:0] S_RST_HOLD = 4'd0;
   localparam logic [3:0] S_CKE_WAIT = 4'd1;
   localparam logic [3:0] S_MRS2     = 4'd2;
   localparam logic [3:0] S_MRS3     = 4'd3;
   localparam logic [3:0] S_MRS1     = 4'd4;
   localparam logic [3:0] S_MRS0     = 4'd5;
   localparam logic [3:0] S_ZQCL     = 4'd6;
   localparam logic [3:0] S_IDLE     = 4'd7;
   localparam logic [3:0] S_REF_WAIT = 4'd8;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_DES = 4'b1111;
   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_MRS = 4'b0000;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_ZQ  = 4'b0110;

   localparam logic [ADDR_W-1:0] ZQ_ADDR = ADDR_W'(1) << 10;

   logic [3:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [REFI_W-1:0]    refi_q, refi_d;
   logic [3:0]           pend_q, pend_d;
   logic [4:0]           pend_sum;
   logic                 rstn_q, rstn_d, cke_q, cke_d;
   logic [3:0]           cmd_q, cmd_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [BANK_BITS-1:0] ba_q, ba_d;
   logic                 ready_q, ready_d, rbusy_q, rbusy_d, ovf_q, ovf_d;
   logic                 can_issue, issue, wrap;

   assign can_issue = (pend_q != 4'd0) && !usr_busy_i;
   assign wrap      = ready_q && (refi_q == REFI_W'(T_REFI - 1));

   // Outputs are registered from next-state values so the pins line up with state_q.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      rstn_d  = rstn_q;
      cke_d   = cke_q;
      ready_d = ready_q;
      cmd_d   = CMD_NOP;
      addr_d  = '0;
      ba_d    = '0;
      issue   = 1'b0;
      case (state_q)
         S_RST_HOLD: begin
            cmd_d = CMD_DES;
            if (cnt_q == CNT_W'(T_RESET_CYC - 1)) begin
               state_d = S_CKE_WAIT;
               cnt_d   = '0;
               rstn_d  = 1'b1;
            end
         end
         S_CKE_WAIT: begin
            cmd_d = CMD_DES;
            if (cnt_q == CNT_W'(T_CKE_CYC - 1)) begin
               state_d = S_MRS2;
               cnt_d   = '0;
               cke_d   = 1'b1;
               cmd_d   = CMD_MRS;
               ba_d    = BANK_BITS'(2);
               addr_d  = MR2_VAL;
            end
         end
         S_MRS2: if (cnt_q == CNT_W'(T_MRD - 1)) begin
            state_d = S_MRS3;
            cnt_d   = '0;
            cmd_d   = CMD_MRS;
            ba_d    = BANK_BITS'(3);
            addr_d  = MR3_VAL;
         end
         S_MRS3: if (cnt_q == CNT_W'(T_MRD - 1)) begin
            state_d = S_MRS1;
            cnt_d   = '0;
            cmd_d   = CMD_MRS;
            ba_d    = BANK_BITS'(1);
            addr_d  = MR1_VAL;
         end
         S_MRS1: if (cnt_q == CNT_W'(T_MRD - 1)) begin
            state_d = S_MRS0;
            cnt_d   = '0;
            cmd_d   = CMD_MRS;
            ba_d    = BANK_BITS'(0);
            addr_d  = MR0_VAL;
         end
         S_MRS0: if (cnt_q == CNT_W'(T_MOD - 1)) begin
            state_d = S_ZQCL;
            cnt_d   = '0;
            cmd_d   = CMD_ZQ;
            addr_d  = ZQ_ADDR;
         end
         S_ZQCL: if (cnt_q == CNT_W'(T_ZQINIT - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
         end
         S_IDLE: begin
            cnt_d = cnt_q;
            if (can_issue) begin
               state_d = S_REF_WAIT;
               cnt_d   = '0;
               cmd_d   = CMD_REF;
               issue   = 1'b1;
            end
         end
         S_REF_WAIT: if (cnt_q == CNT_W'(T_RFC - 1)) begin
            // Chaining straight into the next REF keeps back-to-back spacing at tRFC.
            cnt_d = '0;
            if (can_issue) begin
               cmd_d = CMD_REF;
               issue = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_RST_HOLD;
            cnt_d   = '0;
            cmd_d   = CMD_DES;
         end
      endcase

      refi_d = (!ready_q || wrap) ? '0 : refi_q + 1'b1;
      pend_sum = {1'b0, pend_q} + {4'b0, wrap} - {4'b0, issue};
      pend_d = pend_sum[3:0];
      ovf_d  = ovf_q;
      if (pend_sum > 5'd8) begin
         pend_d = 4'd8;
         ovf_d  = 1'b1;
      end
      rbusy_d = (state_d == S_REF_WAIT);
   end

   always_ff @(posedge in_ddr_clock_i or posedge in_reset_p_i) begin
      if (in_reset_p_i) begin
         state_q <= S_RST_HOLD;
         cnt_q   <= '0;
         refi_q  <= '0;
         pend_q  <= '0;
         rstn_q  <= 1'b0;
         cke_q   <= 1'b0;
         cmd_q   <= CMD_DES;
         addr_q  <= '0;
         ba_q    <= '0;
         ready_q <= 1'b0;
         rbusy_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         refi_q  <= refi_d;
         pend_q  <= pend_d;
         rstn_q  <= rstn_d;
         cke_q   <= cke_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         ready_q <= ready_d;
         rbusy_q <= rbusy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ddr_reset_n_o  = rstn_q;
   assign ctl_cke_o      = cke_q;
   assign ctl_cs_n_o     = cmd_q[3];
   assign ctl_ras_n_o    = cmd_q[2];
   assign ctl_cas_n_o    = cmd_q[1];
   assign ctl_we_n_o     = cmd_q[0];
   assign ctl_odt_o      = 1'b0;
   assign ctl_addr_o     = addr_q;
   assign ctl_ba_o       = ba_q;
   assign ready_o        = ready_q;
   assign ref_busy_o     = rbusy_q;
   assign ref_overflow_o = ovf_q;

endmodule

// File: tb/tb_sddr_init_refresh.sv
// Cycle-accurate check of the init sequence and refresh scheduling against a
// timeline/pending-count model, with literal pins on key event cycles.
module tb_sddr_init_refresh;
   localparam int AW = 14, BW = 3;
   localparam int TR = 20, TC = 10, TMRD = 4, TMOD = 12, TZQ = 32, TREFI = 100, TRFC = 16;
   localparam logic [AW-1:0] MR0 = 14'h0520, MR1 = 14'h0006, MR2 = 14'h0018, MR3 = 14'h0000;
   localparam int T_MRS0 = TR + TC;
   localparam int T_ZQC  = T_MRS0 + 3*TMRD + TMOD;
   localparam int T_IDLE = T_ZQC + TZQ;

   logic clk = 1'b0, rst = 1'b0, busy = 1'b0;
   logic rstn, cke, cs_n, ras_n, cas_n, we_n, odt, ready, rbusy, ovf;
   logic [AW-1:0] addr;
   logic [BW-1:0] ba;

   sddr_init_refresh #(
      .T_RESET_CYC(TR), .T_CKE_CYC(TC), .T_MRD(TMRD), .T_MOD(TMOD), .T_ZQINIT(TZQ),
      .T_REFI(TREFI), .T_RFC(TRFC), .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
   ) dut (
      .in_ddr_clock_i(clk), .in_reset_p_i(rst), .usr_busy_i(busy),
      .ddr_reset_n_o(rstn), .ctl_cke_o(cke), .ctl_cs_n_o(cs_n), .ctl_ras_n_o(ras_n),
      .ctl_cas_n_o(cas_n), .ctl_we_n_o(we_n), .ctl_odt_o(odt), .ctl_addr_o(addr),
      .ctl_ba_o(ba), .ready_o(ready), .ref_busy_o(rbusy), .ref_overflow_o(ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc, m_pend, m_last_ref, bs, be;
   bit m_ovf, busy_prev;
   logic [BW-1:0] ba_tab [4] = '{3'd2, 3'd3, 3'd1, 3'd0};
   logic [AW-1:0] mr_tab [4] = '{MR2, MR3, MR1, MR0};
   int refs[$], mrs_cyc[$];
   int rstn_rise, cke_rise, zq_cyc, rdy_rise, ovf_rise;
   logic [AW-1:0] zq_addr, mrs0_addr;

   function automatic logic [26:0] act_vec();
      return {rstn, cke, cs_n, ras_n, cas_n, we_n, odt, addr, ba, ready, rbusy, ovf};
   endfunction

   task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      int p, np;
      bit issue, wrap;
      logic [3:0] ecmd;
      logic [AW-1:0] eaddr;
      logic [BW-1:0] eba;
      @(posedge clk); #1;
      cyc++;
      p = cyc - 1;
      // refresh model: a wrap or issue decided in cycle p shows on the pins in cycle cyc
      issue = (p >= T_IDLE) && (m_pend > 0) && !busy_prev && (cyc >= m_last_ref + TRFC);
      wrap  = (p >= T_IDLE) && ((p - T_IDLE) % TREFI == TREFI - 1);
      np = m_pend - int'(issue) + int'(wrap);
      if (np > 8) begin np = 8; m_ovf = 1'b1; end
      m_pend = np;
      if (issue) m_last_ref = cyc;

      ecmd = (cyc < T_MRS0) ? 4'b1111 : 4'b0111;
      eaddr = '0;
      eba = '0;
      for (int i = 0; i < 4; i++)
         if (cyc == T_MRS0 + i*TMRD) begin ecmd = 4'b0000; eba = ba_tab[i]; eaddr = mr_tab[i]; end
      if (cyc == T_ZQC) begin ecmd = 4'b0110; eaddr = AW'(1) << 10; end
      if (cyc == m_last_ref) ecmd = 4'b0001;
      check("cycle_outputs", act_vec(),
            {cyc >= TR, cyc >= T_MRS0, ecmd, 1'b0, eaddr, eba, cyc >= T_IDLE,
             (cyc >= m_last_ref) && (cyc < m_last_ref + TRFC), m_ovf});

      if (rstn === 1'b1 && rstn_rise < 0) rstn_rise = cyc;
      if (cke === 1'b1 && cke_rise < 0) cke_rise = cyc;
      if (ready === 1'b1 && rdy_rise < 0) rdy_rise = cyc;
      if (ovf === 1'b1 && ovf_rise < 0) ovf_rise = cyc;
      if ({cs_n, ras_n, cas_n, we_n} === 4'b0000) begin
         mrs_cyc.push_back(cyc);
         if (ba === 3'd0) mrs0_addr = addr;
      end
      if ({cs_n, ras_n, cas_n, we_n} === 4'b0110) begin zq_cyc = cyc; zq_addr = addr; end
      if ({cs_n, ras_n, cas_n, we_n} === 4'b0001) refs.push_back(cyc);

      busy = (cyc >= bs) && (cyc < be);
      busy_prev = busy;
   endtask

   task automatic do_reset();
      #3 rst = 1'b1;
      #1 check("reset_values", act_vec(), {2'b00, 4'b1111, 1'b0, {AW{1'b0}}, {BW{1'b0}}, 3'b000});
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cyc = 0; m_pend = 0; m_ovf = 1'b0; m_last_ref = -1000;
      busy = 1'b0; busy_prev = 1'b0;
      refs.delete(); mrs_cyc.delete();
      rstn_rise = -1; cke_rise = -1; zq_cyc = -1; rdy_rise = -1; ovf_rise = -1;
      zq_addr = '0; mrs0_addr = '0;
   endtask

   initial begin
      // free-running refresh, then reset lands inside a REF_WAIT window
      do_reset();
      bs = 0; be = 0;
      repeat (390) step();
      check_int("rstn_rise", rstn_rise, 20);
      check_int("cke_rise", cke_rise, 30);
      check_int("mrs_count", mrs_cyc.size(), 4);
      check_int("mrs2_cyc", mrs_cyc[0], 30);
      check_int("mrs3_cyc", mrs_cyc[1], 34);
      check_int("mrs1_cyc", mrs_cyc[2], 38);
      check_int("mrs0_cyc", mrs_cyc[3], 42);
      check_int("mrs0_addr", int'(mrs0_addr), 'h0520);
      check_int("zq_cyc", zq_cyc, 54);
      check_int("zq_addr", int'(zq_addr), 'h0400);
      check_int("ready_rise", rdy_rise, 86);
      check_int("free_ref_count", refs.size(), 3);
      check_int("free_ref0", refs[0], 187);
      check_int("free_ref1", refs[1], 287);
      check_int("free_ref2", refs[2], 387);
      check_int("in_ref_wait", int'(rbusy), 1);

      // busy for 350 cycles after IDLE: three owed REFs drain tRFC apart
      do_reset();
      bs = T_IDLE; be = T_IDLE + 350;
      repeat (520) step();
      check_int("b_ready_rise", rdy_rise, 86);
      check_int("b_ref0", refs[0], 437);
      check_int("b_ref1", refs[1], 453);
      check_int("b_ref2", refs[2], 469);
      check_int("b_no_ovf", ovf_rise, -1);

      // busy for 950 cycles: ninth wrap overflows, eight banked REFs drain
      do_reset();
      bs = T_IDLE; be = T_IDLE + 950;
      repeat (1200) step();
      check_int("c_ovf_rise", ovf_rise, 986);
      check_int("c_ref0", refs[0], 1037);
      check_int("c_ref7", refs[7], 1149);

      do_reset();
      repeat (100) step();
      check_int("d_ready_rise", rdy_rise, 86);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sddr_init_refresh.md
SDDR_INIT_REFRESH -- requirements
Module: sddr_init_refresh

Interface
REQ-001 SHALL have parameter BANK_BITS, default 3: bank address width.
REQ-002 SHALL have parameter ROW_BITS, default 13: row address width.
REQ-003 SHALL have parameter DATA_BITS, default 16: DQ width; address width is ADDR_W = ROW_BITS+$clog2(DATA_BITS/8).
REQ-004 SHALL have parameters T_RESET_CYC=40000, T_CKE_CYC=100000, T_MRD=4, T_MOD=12, T_ZQINIT=512, T_REFI=6240, T_RFC=128, all in ddr clock cycles, each >=2.
REQ-005 SHALL have parameters MR0_VAL, MR1_VAL, MR2_VAL, MR3_VAL, each ADDR_W bits, default 0: mode register contents.
REQ-006 Clock and reset (already decided): one clock, in_ddr_clock_i; reset in_reset_p_i is asynchronous and active-high.
REQ-007 in_ddr_clock_i  in  1  DDR controller clock; all logic on its rising edge.
REQ-008 in_reset_p_i  in  1  asynchronous active-high reset.
REQ-009 usr_busy_i  in  1  upstream has a transfer in flight; refresh is deferred while high.
REQ-010 ddr_reset_n_o  out  1  to PHY in_ddr_reset_n_i.
REQ-011 ctl_cke_o, ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o, ctl_odt_o  out  1 each  command pins to PHY.
REQ-012 ctl_addr_o  out  ADDR_W  address to PHY; ctl_ba_o  out  BANK_BITS  bank to PHY.
REQ-013 ready_o  out  1  initialization done, controller may issue user commands.
REQ-014 ref_busy_o  out  1  refresh command issued or tRFC window running.
REQ-015 ref_overflow_o  out  1  sticky: ninth refresh owed while eight pending.

Function
REQ-016 All outputs SHALL be registered; ctl_odt_o SHALL be constant 0.
REQ-017 States SHALL be RST_HOLD, CKE_WAIT, MRS2, MRS3, MRS1, MRS0, ZQCL, IDLE, REF_WAIT.
REQ-018 RST_HOLD: ddr_reset_n_o=0, ctl_cke_o=0, ctl_cs_n_o=1 for T_RESET_CYC cycles, then CKE_WAIT.
REQ-019 CKE_WAIT: ddr_reset_n_o=1, ctl_cke_o=0, deselect for T_CKE_CYC cycles; then ctl_cke_o=1 and MRS2.
REQ-020 MRSn: one-cycle command cs/ras/cas/we=0000, ba=n, addr=MRn_VAL; then NOP for T_MRD-1 cycles (T_MOD-1 after MRS0) before next state.
REQ-021 ZQCL: one-cycle command 0110, addr[10]=1, other addr bits 0, ba=0; then NOP for T_ZQINIT-1 cycles; then IDLE with ready_o=1 from that cycle.
REQ-022 NOP encoding SHALL be cs/ras/cas/we=0111; deselect cs_n=1 with ras/cas/we=1; addr/ba SHALL be 0 outside MRS/ZQCL.
REQ-023 ready_o SHALL remain 1 from first IDLE until reset.
REQ-024 Refresh interval counter SHALL start on first IDLE entry, count T_REFI cycles, and wrap, adding one to pending-refresh count (0..8) at each wrap.
REQ-025 Wrap with pending=8 SHALL set ref_overflow_o and leave pending at 8.
REQ-026 In IDLE with pending>0 and usr_busy_i=0: issue one-cycle REF (0001), decrement pending, enter REF_WAIT; ref_busy_o=1 from the REF cycle for T_RFC cycles; NOP throughout; then IDLE.
REQ-027 Wrap coincident with REF issue SHALL net pending unchanged.
REQ-028 usr_busy_i rising during REF_WAIT SHALL not abort it; back-to-back REFs SHALL be spaced exactly T_RFC cycles.
REQ-029 Outside IDLE/REF_WAIT, usr_busy_i SHALL be ignored.

Reset
REQ-030 in_reset_p_i high SHALL immediately force: state RST_HOLD, ddr_reset_n_o=0, ctl_cke_o=0, ctl_cs_n_o=1, ras/cas/we=1, addr=0, ba=0, ready_o=0, ref_busy_o=0, ref_overflow_o=0, all counters 0, pending=0.
REQ-031 Reset asserted mid-sequence or mid-refresh SHALL restart from RST_HOLD on release, full durations.

Verification (T_RESET_CYC=20, T_CKE_CYC=10, T_MRD=4, T_MOD=12, T_ZQINIT=32, T_REFI=100, T_RFC=16, MR0_VAL=0x0520)
REQ-032 Release reset -> ddr_reset_n_o rises cycle 20, cke rises cycle 30, MRS ba=2,3,1,0 at cycles 30,34,38,42 with MRS0 addr=0x0520.
REQ-033 Continue -> ZQCL at cycle 54 with addr=0x0400, ready_o=1 at cycle 86.
REQ-034 usr_busy_i=0 -> REF every 100 cycles, ref_busy_o high exactly 16 cycles each.
REQ-035 usr_busy_i=1 for 350 cycles after IDLE -> three REFs issued 16 cycles apart when it drops, ref_overflow_o stays 0.
REQ-036 usr_busy_i=1 for 950 cycles -> ref_overflow_o=1 at ninth wrap, eight REFs after release.
REQ-037 Reset pulse during REF_WAIT -> outputs at reset values same cycle; full init repeats.
